// File: rtl/lot_controller.sv
// rtl/lot_controller.sv - two-gate parking lot entry/occupancy controller
//
// Purpose : grants entry barriers against free spaces (round-robin when only
//           one space is left), tracks occupancy from enter/exit pulses and
//           flags protocol violations.
// Macro   : LOT_TIMEOUT_EN - when defined, an opened barrier closes on its own
//           after TIMEOUT cycles without an enter pulse.
// Ports   : clk              rising-edge clock
//           reset            asynchronous active-low reset
//           req0/req1        car waiting at entry gate 0/1 (level)
//           enter0/enter1    car fully entered through gate 0/1 (pulse)
//           exit0/exit1      car fully exited at gate 0/1 (pulse)
//           open0/open1      barrier-open command (registered)
//           count            occupied spaces (registered)
//           full/empty       occupancy status (registered)
//           err              sticky protocol-violation flag
module lot_controller #(
   parameter int CAPACITY = 16,
   parameter int CNT_W    = 8,
   parameter int TIMEOUT  = 100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic             enter0,
   input  logic             enter1,
   input  logic             exit0,
   input  logic             exit1,
   output logic             open0,
   output logic             open1,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             err
);

   // Two spare bits so count + reservations never wraps in the arithmetic.
   localparam int SW = CNT_W + 2;

   if (CAPACITY < 1 || CAPACITY > 255 || (1 << CNT_W) <= CAPACITY || TIMEOUT < 1) begin : g_bad_param
      $error("lot_controller: illegal parameter combination");
   end

   typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} gate_state_e;

   gate_state_e      st0_q, st0_d, st1_q, st1_d;
   logic             rr_q, rr_d;        // 0: gate 0 wins the next contention
   logic             armed_q;           // blocks grants on the first edge after reset
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d, err_q, err_d;
   logic             expire0, expire1;

   logic [SW-1:0]    resv, resv_nxt, free, avail, avail2, cnt_next;
   logic             want0, want1, grant0, grant1;
   logic             acc_en0, acc_en1, acc_x0, acc_x1;

`ifdef LOT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmr0_q, tmr1_q;

   // Timers hold zero while IDLE, so they start from zero on every grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmr0_q <= '0;
         tmr1_q <= '0;
      end else begin
         tmr0_q <= (st0_q == OPEN) ? tmr0_q + 1'b1 : '0;
         tmr1_q <= (st1_q == OPEN) ? tmr1_q + 1'b1 : '0;
      end
   end

   assign expire0 = (st0_q == OPEN) && (tmr0_q == TW'(TIMEOUT - 1));
   assign expire1 = (st1_q == OPEN) && (tmr1_q == TW'(TIMEOUT - 1));
`else
   assign expire0 = 1'b0;
   assign expire1 = 1'b0;
`endif

   always_comb begin
      resv    = SW'(st0_q == OPEN) + SW'(st1_q == OPEN);
      free    = SW'(CAPACITY) - SW'(count_q) - resv;
      acc_en0 = enter0 && (st0_q == OPEN);
      acc_en1 = enter1 && (st1_q == OPEN);

      // Only gates IDLE right now may be granted; a gate closing this edge
      // is still OPEN here, so it is re-evaluated next cycle.
      want0  = armed_q && (st0_q == IDLE) && req0;
      want1  = armed_q && (st1_q == IDLE) && req1;
      grant0 = 1'b0;
      grant1 = 1'b0;
      rr_d   = rr_q;
      if (want0 && want1) begin
         if (free >= SW'(2)) begin
            grant0 = 1'b1;
            grant1 = 1'b1;
         end else if (free == SW'(1)) begin
            grant0 = !rr_q;
            grant1 = rr_q;
            rr_d   = !rr_q;
         end
      end else if (want0 && free != '0) begin
         grant0 = 1'b1;
      end else if (want1 && free != '0) begin
         grant1 = 1'b1;
      end

      st0_d = st0_q;
      if (st0_q == OPEN && (acc_en0 || expire0)) st0_d = IDLE;
      if (grant0) st0_d = OPEN;
      st1_d = st1_q;
      if (st1_q == OPEN && (acc_en1 || expire1)) st1_d = IDLE;
      if (grant1) st1_d = OPEN;

      // Enters land first so a same-cycle exit of the entering car is legal.
      avail    = SW'(count_q) + SW'(acc_en0) + SW'(acc_en1);
      acc_x0   = exit0 && (avail != '0);
      avail2   = avail - SW'(acc_x0);
      acc_x1   = exit1 && (avail2 != '0);
      cnt_next = avail2 - SW'(acc_x1);
      count_d  = cnt_next[CNT_W-1:0];

      err_d = err_q
            | (enter0 && st0_q == IDLE) | (enter1 && st1_q == IDLE)
            | (exit0 && !acc_x0) | (exit1 && !acc_x1);

      resv_nxt = SW'(st0_d == OPEN) + SW'(st1_d == OPEN);
      full_d   = (cnt_next + resv_nxt) == SW'(CAPACITY);
      empty_d  = (cnt_next == '0) && (resv_nxt == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st0_q   <= IDLE;
         st1_q   <= IDLE;
         rr_q    <= 1'b0;
         armed_q <= 1'b0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         st0_q   <= st0_d;
         st1_q   <= st1_d;
         rr_q    <= rr_d;
         armed_q <= 1'b1;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         err_q   <= err_d;
      end
   end

   assign open0 = (st0_q == OPEN);
   assign open1 = (st1_q == OPEN);
   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;
   assign err   = err_q;

endmodule

// File: tb/tb_lot_controller.sv
// tb/tb_lot_controller.sv - randomized and directed bench for lot_controller
module tb_lot_controller;

   localparam int CAP = 8;
   localparam int TMO = 100;

   logic clk = 1'b0;
   logic reset;
   logic req0, req1, enter0, enter1, exit0, exit1;
   logic open0, open1, full, empty, err;
   logic [3:0] count;
   logic s_open0, s_open1, s_full, s_empty, s_err;
   logic [1:0] s_count;

   int n_checks = 0;
   int n_errors = 0;

   // Occupancy model: plain counters and flags derived from the lot rules.
   int m_count;
   int m_age[2];
   bit m_open[2];
   bit m_ptr, m_err, m_ready, m_full, m_empty;

   always #5 clk = ~clk;

   lot_controller #(.CAPACITY(CAP), .CNT_W(4), .TIMEOUT(TMO)) u_dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .enter0(enter0), .enter1(enter1), .exit0(exit0), .exit1(exit1),
      .open0(open0), .open1(open1), .count(count),
      .full(full), .empty(empty), .err(err));

   lot_controller #(.CAPACITY(2), .CNT_W(2), .TIMEOUT(TMO)) u_small (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .enter0(enter0), .enter1(enter1), .exit0(exit0), .exit1(exit1),
      .open0(s_open0), .open1(s_open1), .count(s_count),
      .full(s_full), .empty(s_empty), .err(s_err));

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_count = 0; m_open[0] = 0; m_open[1] = 0; m_age[0] = 0; m_age[1] = 0;
      m_ptr = 0; m_err = 0; m_ready = 0; m_full = 0; m_empty = 1;
   endtask

   task automatic model_step(input bit r0, r1, e0, e1, x0, x1);
      int  free, entered;
      bit  nxt[2], e[2], x[2], w0, w1;
      e[0] = e0; e[1] = e1; x[0] = x0; x[1] = x1;
      free = CAP - m_count - int'(m_open[0]) - int'(m_open[1]);
      entered = 0;
      for (int g = 0; g < 2; g++) begin
         nxt[g] = m_open[g];
         if (m_open[g]) begin
            if (e[g]) begin
               entered++;
               nxt[g] = 0;
            end else begin
               m_age[g]++;
`ifdef LOT_TIMEOUT_EN
               if (m_age[g] >= TMO) nxt[g] = 0;
`endif
            end
         end else if (e[g]) begin
            m_err = 1;
         end
      end
      w0 = m_ready && !m_open[0] && r0;
      w1 = m_ready && !m_open[1] && r1;
      if (w0 && w1) begin
         if (free >= 2) begin
            nxt[0] = 1; nxt[1] = 1; m_age[0] = 0; m_age[1] = 0;
         end else if (free == 1) begin
            nxt[m_ptr] = 1; m_age[m_ptr] = 0; m_ptr = !m_ptr;
         end
      end else if (w0 && free > 0) begin
         nxt[0] = 1; m_age[0] = 0;
      end else if (w1 && free > 0) begin
         nxt[1] = 1; m_age[1] = 0;
      end
      m_count += entered;
      for (int g = 0; g < 2; g++)
         if (x[g]) begin
            if (m_count > 0) m_count--;
            else m_err = 1;
         end
      m_open[0] = nxt[0];
      m_open[1] = nxt[1];
      m_full  = (m_count + int'(nxt[0]) + int'(nxt[1])) == CAP;
      m_empty = (m_count == 0) && !nxt[0] && !nxt[1];
      m_ready = 1;
   endtask

   task automatic cycle(input bit r0, r1, e0, e1, x0, x1);
      @(negedge clk);
      req0 = r0; req1 = r1; enter0 = e0; enter1 = e1; exit0 = x0; exit1 = x1;
      @(posedge clk);
      model_step(r0, r1, e0, e1, x0, x1);
      #1;
      check("open0", open0, int'(m_open[0]));
      check("open1", open1, int'(m_open[1]));
      check("count", count, m_count);
      check("full", full, int'(m_full));
      check("empty", empty, int'(m_empty));
      check("err", err, int'(m_err));
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0);
   endtask

   task automatic admit(input bit g);
      cycle(!g, g, 0, 0, 0, 0);
      cycle(0, 0, !g, g, 0, 0);
   endtask

   // Reset asserted mid-low-phase; outputs must clear before any clk edge.
   task automatic do_reset();
      @(negedge clk);
      req0 = 0; req1 = 0; enter0 = 0; enter1 = 0; exit0 = 0; exit1 = 0;
      reset = 1'b0;
      #1;
      model_reset();
      check("rst_open0", open0, 0);
      check("rst_open1", open1, 0);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_err", err, 0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic random_run(input int n);
      bit r0, r1, e0, e1, x0, x1;
      for (int i = 0; i < n; i++) begin
         r0 = ($urandom_range(0, 2) != 0);
         r1 = ($urandom_range(0, 2) != 0);
         e0 = m_open[0] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
         e1 = m_open[1] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
         x0 = ($urandom_range(0, 6) == 0);
         x1 = ($urandom_range(0, 6) == 0);
         cycle(r0, r1, e0, e1, x0, x1);
      end
   endtask

   initial begin
      int high;
      reset = 1'b0;
      req0 = 0; req1 = 0; enter0 = 0; enter1 = 0; exit0 = 0; exit1 = 0;
      model_reset();
      do_reset();

      // Single grant then entry.
      idle();
      cycle(1, 0, 0, 0, 0, 0);
      check("grant_open0", open0, 1);
      cycle(0, 0, 1, 0, 0, 0);
      check("enter_open0", open0, 0);
      check("enter_count", count, 1);
      check("enter_empty", empty, 0);

      // One space left in the small lot: round-robin contention.
      cycle(1, 1, 0, 0, 0, 0);
      check("rr1_s_open0", s_open0, 1);
      check("rr1_s_open1", s_open1, 0);
      check("rr1_s_full", s_full, 1);
      cycle(0, 0, 1, 0, 0, 0);
      check("rr1_s_count", s_count, 2);
      check("rr1_s_full2", s_full, 1);
      cycle(0, 0, 0, 0, 1, 0);
      check("rr1_s_count2", s_count, 1);
      cycle(1, 1, 0, 0, 0, 0);
      check("rr2_s_open0", s_open0, 0);
      check("rr2_s_open1", s_open1, 1);
      do_reset();

      // Exit on empty lot is dropped and flagged.
      idle();
      cycle(0, 0, 0, 0, 0, 1);
      check("underflow_count", count, 0);
      check("underflow_err", err, 1);
      repeat (5) idle();
      check("err_sticky", err, 1);
      do_reset();

      // Enter and two exits in one cycle.
      idle();
      admit(0); admit(1); admit(0);
      check("three_count", count, 3);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 1, 1);
      check("same_cycle_count", count, 2);
      do_reset();

      // Barrier timeout (or hold when the timer is absent).
      idle();
      cycle(0, 1, 0, 0, 0, 0);
      high = open1 ? 1 : 0;
      for (int i = 0; i < 1000; i++) begin
         idle();
         if (open1) high++;
      end
`ifdef LOT_TIMEOUT_EN
      check("timeout_cycles", high, TMO);
`else
      check("hold_cycles", high, 1001);
`endif
      check("timeout_count", count, 0);

      // Reset mid-OPEN with five cars parked.
      repeat (5) admit(0);
      cycle(1, 0, 0, 0, 0, 0);
      check("pre_rst_open0", open0, 1);
      check("pre_rst_count", count, 5);
      do_reset();

      idle();
      random_run(2000);
      do_reset();
      idle();
      random_run(2000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
